// File: rtl/trap_controller_if.sv
// Signal bundle between the trap controller and the core (ID stage, IRQ lines, CSRs, fetch redirect).
// The controller uses the slave modport; the driving side (pipeline/CSR file) uses master.
interface trap_controller_if #(
  parameter int XLEN        = 32,
  parameter int EXC_CAUSE_W = 4
);
  logic                   id_valid;
  logic [XLEN-1:0]        id_pc;
  logic                   exc_valid_id;
  logic [EXC_CAUSE_W-1:0] exc_cause_id;
  logic                   mret_id;
  logic                   irq_ext;
  logic                   irq_sw;
  logic                   irq_timer;
  logic                   mstatus_mie;
  logic [2:0]             mie_mask;
  logic [XLEN-1:0]        mtvec;
  logic [XLEN-1:0]        mepc;
  logic                   pipe_empty;

  logic                   control_stall_if;
  logic                   control_stall_id;
  logic                   trap_pc_valid;
  logic [XLEN-1:0]        trap_pc;
  logic                   csr_trap_we;
  logic [XLEN-1:0]        csr_mepc;
  logic [XLEN-1:0]        csr_mcause;
  logic                   csr_mret_we;
  logic                   busy;

  modport master (
    output id_valid, id_pc, exc_valid_id, exc_cause_id, mret_id,
           irq_ext, irq_sw, irq_timer, mstatus_mie, mie_mask,
           mtvec, mepc, pipe_empty,
    input  control_stall_if, control_stall_id, trap_pc_valid, trap_pc,
           csr_trap_we, csr_mepc, csr_mcause, csr_mret_we, busy
  );

  modport slave (
    input  id_valid, id_pc, exc_valid_id, exc_cause_id, mret_id,
           irq_ext, irq_sw, irq_timer, mstatus_mie, mie_mask,
           mtvec, mepc, pipe_empty,
    output control_stall_if, control_stall_id, trap_pc_valid, trap_pc,
           csr_trap_we, csr_mepc, csr_mcause, csr_mret_we, busy
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: freezes IF/ID, drains EX/MEM/WB, then redirects fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
//
// state | meaning
// IDLE  | no trap in progress, acceptance allowed
// DRAIN | IF/ID held, waiting for EX/MEM/WB to empty
// TRAP  | one-cycle trap entry strobe (redirect + CSR trap update)
// RET   | one-cycle MRET strobe (redirect to mepc + CSR status restore)
module trap_controller #(
  parameter int XLEN        = 32,
  parameter int EXC_CAUSE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  trap_controller_if.slave  bus
);

  localparam int CODE_W = (EXC_CAUSE_W > 4) ? EXC_CAUSE_W : 4;

  localparam logic [CODE_W-1:0] C_IRQ_EXT   = CODE_W'(11);
  localparam logic [CODE_W-1:0] C_IRQ_SW    = CODE_W'(3);
  localparam logic [CODE_W-1:0] C_IRQ_TIMER = CODE_W'(7);
  localparam logic [XLEN-1:0]   C_ALIGN_MSK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_TRAP  = 2'd2,
    S_RET   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_EXC  = 2'd0,
    K_IRQ  = 2'd1,
    K_MRET = 2'd2
  } kind_t;

  state_t              r_state;
  state_t              w_state_nxt;
  kind_t               r_kind;
  kind_t               w_kind_nxt;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   w_code_nxt;
  logic [XLEN-1:0]     r_pc;

  logic [2:0]          w_irq_act;
  logic                w_irq_pend;
  logic [CODE_W-1:0]   w_irq_code;
  logic                w_accept;
  logic [XLEN-1:0]     w_base;
  logic [XLEN-1:0]     w_code_ext;

  logic                w_stall;
  logic                w_pc_valid;
  logic [XLEN-1:0]     w_trap_pc;
  logic                w_trap_we;
  logic                w_mret_we;
  logic [XLEN-1:0]     w_mepc;
  logic [XLEN-1:0]     w_mcause;

  // Enabled interrupt sources, ordered {ext, sw, timer}
  assign w_irq_act  = {bus.irq_ext, bus.irq_sw, bus.irq_timer} & bus.mie_mask;
  assign w_irq_pend = bus.mstatus_mie & (|w_irq_act);

  always_comb begin
    w_irq_code = C_IRQ_TIMER;
    if (w_irq_act[2]) begin
      w_irq_code = C_IRQ_EXT;
    end else if (w_irq_act[1]) begin
      w_irq_code = C_IRQ_SW;
    end
  end

  // Gated by reset so the stall outputs drop immediately on an async reset
  assign w_accept = !reset && (r_state == S_IDLE) && bus.id_valid &&
                    (bus.exc_valid_id || bus.mret_id || w_irq_pend);

  assign w_base     = bus.mtvec & C_ALIGN_MSK;
  assign w_code_ext = XLEN'(r_code);
  assign w_stall    = (r_state != S_IDLE) || w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= K_EXC;
      r_code  <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_kind <= w_kind_nxt;
        r_code <= w_code_nxt;
        r_pc   <= bus.id_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_code_nxt  = r_code;
    w_pc_valid  = 1'b0;
    w_trap_pc   = '0;
    w_trap_we   = 1'b0;
    w_mret_we   = 1'b0;
    w_mepc      = '0;
    w_mcause    = '0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DRAIN;
          if (bus.exc_valid_id) begin
            w_kind_nxt = K_EXC;
            w_code_nxt = CODE_W'(bus.exc_cause_id);
          end else if (bus.mret_id) begin
            w_kind_nxt = K_MRET;
            w_code_nxt = '0;
          end else begin
            w_kind_nxt = K_IRQ;
            w_code_nxt = w_irq_code;
          end
        end
      end

      S_DRAIN: begin
        if (bus.pipe_empty) begin
          w_state_nxt = (r_kind == K_MRET) ? S_RET : S_TRAP;
        end
      end

      S_TRAP: begin
        w_state_nxt       = S_IDLE;
        w_pc_valid        = 1'b1;
        w_trap_we         = 1'b1;
        w_mepc            = r_pc;
        w_mcause          = w_code_ext;
        w_mcause[XLEN-1]  = (r_kind == K_IRQ);
`ifdef TRAP_VECTORED_EN
        if ((r_kind == K_IRQ) && (bus.mtvec[1:0] == 2'b01)) begin
          w_trap_pc = w_base + (w_code_ext << 2);
        end else begin
          w_trap_pc = w_base;
        end
`else
        w_trap_pc = w_base;
`endif
      end

      S_RET: begin
        w_state_nxt = S_IDLE;
        w_pc_valid  = 1'b1;
        w_mret_we   = 1'b1;
        w_trap_pc   = bus.mepc & C_ALIGN_MSK;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.control_stall_if = w_stall;
  assign bus.control_stall_id = w_stall;
  assign bus.trap_pc_valid    = w_pc_valid;
  assign bus.trap_pc          = w_trap_pc;
  assign bus.csr_trap_we      = w_trap_we;
  assign bus.csr_mepc         = w_mepc;
  assign bus.csr_mcause       = w_mcause;
  assign bus.csr_mret_we      = w_mret_we;
  assign bus.busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized trap/MRET/IRQ cases
// checked against a transaction-level expectation derived from the trap rules.
module tb_trap_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_controller_if #(.XLEN(32), .EXC_CAUSE_W(4)) bus ();

  trap_controller #(.XLEN(32), .EXC_CAUSE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input bit stall, input bit busy,
                            input bit pcv, input bit twe, input bit mwe,
                            input logic [31:0] pc, input logic [31:0] mepc,
                            input logic [31:0] mcause);
    chk({tag, ".stall_if"}, 64'(bus.control_stall_if), 64'(stall));
    chk({tag, ".stall_id"}, 64'(bus.control_stall_id), 64'(stall));
    chk({tag, ".busy"},     64'(bus.busy),             64'(busy));
    chk({tag, ".pc_valid"}, 64'(bus.trap_pc_valid),    64'(pcv));
    chk({tag, ".trap_we"},  64'(bus.csr_trap_we),      64'(twe));
    chk({tag, ".mret_we"},  64'(bus.csr_mret_we),      64'(mwe));
    chk({tag, ".trap_pc"},  64'(bus.trap_pc),          64'(pc));
    chk({tag, ".mepc"},     64'(bus.csr_mepc),         64'(mepc));
    chk({tag, ".mcause"},   64'(bus.csr_mcause),       64'(mcause));
  endtask

  task automatic idle_inputs();
    bus.id_valid     = 1'b0;
    bus.exc_valid_id = 1'b0;
    bus.exc_cause_id = '0;
    bus.mret_id      = 1'b0;
    bus.irq_ext      = 1'b0;
    bus.irq_sw       = 1'b0;
    bus.irq_timer    = 1'b0;
  endtask

  // Everything here must be ignored by the controller while it is busy
  task automatic scramble();
    bus.id_valid     = 1'($urandom);
    bus.exc_valid_id = 1'($urandom);
    bus.exc_cause_id = 4'($urandom);
    bus.mret_id      = 1'($urandom);
    bus.irq_ext      = 1'($urandom);
    bus.irq_sw       = 1'($urandom);
    bus.irq_timer    = 1'($urandom);
    bus.mstatus_mie  = 1'($urandom);
    bus.mie_mask     = 3'($urandom);
  endtask

  // kind: 0 = not accepted, 1 = trap entry, 2 = MRET
  function automatic void predict(input bit v, input bit exc, input logic [3:0] cause,
                                  input bit mret, input logic [2:0] irq, input bit mie,
                                  input logic [2:0] mask, input logic [31:0] mtvec,
                                  input logic [31:0] mepc, output int kind,
                                  output logic [31:0] pc, output logic [31:0] mcause);
    int codes[3] = '{11, 3, 7};
    int lines[3] = '{2, 1, 0};
    int irq_code = -1;
    kind = 0; pc = 0; mcause = 0;
    if (mie) begin
      for (int i = 2; i >= 0; i--)
        if (irq[lines[i]] && mask[lines[i]]) irq_code = codes[i];
    end
    if (!v) return;
    if (exc) begin
      kind = 1; mcause = 32'(cause); pc = (mtvec / 4) * 4;
    end else if (mret) begin
      kind = 2; pc = (mepc / 4) * 4;
    end else if (irq_code >= 0) begin
      kind = 1; mcause = 32'h8000_0000 + 32'(irq_code); pc = (mtvec / 4) * 4;
`ifdef TRAP_VECTORED_EN
      if (mtvec % 4 == 1) pc = pc + 32'(4 * irq_code);
`endif
    end
  endfunction

  task automatic run_case(input string tag, input bit v, input bit exc, input logic [3:0] cause,
                          input bit mret, input logic [2:0] irq, input bit mie,
                          input logic [2:0] mask, input logic [31:0] pc,
                          input logic [31:0] mtvec, input logic [31:0] mepc, input int d);
    int kind;
    logic [31:0] exp_pc, exp_cause;
    predict(v, exc, cause, mret, irq, mie, mask, mtvec, mepc, kind, exp_pc, exp_cause);
    @(negedge clk);
    bus.id_valid = v; bus.exc_valid_id = exc; bus.exc_cause_id = cause; bus.mret_id = mret;
    {bus.irq_ext, bus.irq_sw, bus.irq_timer} = irq;
    bus.mstatus_mie = mie; bus.mie_mask = mask; bus.id_pc = pc;
    bus.mtvec = mtvec; bus.mepc = mepc; bus.pipe_empty = 1'($urandom);
    #1;
    check_outs({tag, ".T"}, kind != 0, 0, 0, 0, 0, 0, 0, 0);
    if (kind == 0) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check_outs({tag, ".noacc"}, 0, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      scramble();
      bus.pipe_empty = (k == d);
      #1;
      check_outs({tag, ".drain"}, 1, 1, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    idle_inputs();
    bus.pipe_empty = 1'($urandom);
    #1;
    if (kind == 1) check_outs({tag, ".trap"}, 1, 1, 1, 1, 0, exp_pc, pc, exp_cause);
    else           check_outs({tag, ".ret"},  1, 1, 1, 0, 1, exp_pc, 0, 0);
    @(negedge clk);
    #1;
    check_outs({tag, ".after"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.mstatus_mie = 1'b0; bus.mie_mask = 3'b000; bus.id_pc = '0;
    bus.mtvec = '0; bus.mepc = '0; bus.pipe_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    run_case("exc_min",   1, 1, 4'd2,  0, 3'b000, 0, 3'b000, 32'h100, 32'h800, 32'h0,   0);
    run_case("exc_drain", 1, 1, 4'd2,  0, 3'b000, 0, 3'b000, 32'h100, 32'h800, 32'h0,   3);
    run_case("irq_prio",  1, 0, 4'd0,  0, 3'b101, 1, 3'b111, 32'h200, 32'h800, 32'h0,   1);
    run_case("irq_off",   1, 0, 4'd0,  0, 3'b111, 0, 3'b111, 32'h200, 32'h800, 32'h0,   0);
    run_case("exc_vs_irq",1, 1, 4'd11, 0, 3'b010, 1, 3'b111, 32'h300, 32'h800, 32'h0,   0);
    run_case("mret",      1, 0, 4'd0,  1, 3'b000, 0, 3'b000, 32'h400, 32'h800, 32'h343, 2);
    run_case("vec_timer", 1, 0, 4'd0,  0, 3'b001, 1, 3'b111, 32'h500, 32'h801, 32'h0,   0);
    run_case("vec_exc",   1, 1, 4'd5,  0, 3'b001, 1, 3'b111, 32'h504, 32'h801, 32'h0,   0);

    // Reset in the middle of DRAIN aborts with no strobe afterwards
    @(negedge clk);
    bus.id_valid = 1; bus.exc_valid_id = 1; bus.exc_cause_id = 4'd4;
    bus.id_pc = 32'h600; bus.mtvec = 32'h800; bus.pipe_empty = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    check_outs("rst_pre", 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.pipe_empty = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_outs("rst_post", 0, 0, 0, 0, 0, 0, 0, 0);
    end

    for (int n = 0; n < 80; n++) begin
      logic [31:0] mtv;
      mtv = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      run_case("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
               $urandom_range(0, 2) == 0, 3'($urandom), 1'($urandom), 3'($urandom),
               $urandom, mtv, $urandom, $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
